vga_capture: RTL

Video-input counterpart of the VGA output block: samples an incoming 640x480 active-low-sync RGB332 stream and writes one 160x120 frame, decimated 4:1 in each axis, into the video RAM. Words use the same 16-bit packing (two pixels per word, row pitch 80 words) that the 8-bit colour display mode reads back. Typical use: frame grabber or loopback test source feeding the CPU-visible framebuffer through the RAM's write port.

---
 rtl/vga_capture_if.sv | 26 ++
 rtl/vga_capture.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/vga_capture_if.sv
// Video input port and RAM write port of the frame capture block.
// master drives the video stream and sinks writes; slave is the capture block.
interface vga_capture_if;
    localparam int unsigned ADDR_W = 15;
    localparam int unsigned DATA_W = 16;

    logic              pix_ce;
    logic              hsync;
    logic              vsync;
    logic [2:0]        r;
    logic [2:0]        g;
    logic [1:0]        b;
    logic              wr_en;
    logic [ADDR_W-1:0] wr_addr;
    logic [DATA_W-1:0] wr_data;

    modport master (
        output pix_ce, hsync, vsync, r, g, b,
        input  wr_en, wr_addr, wr_data
    );

    modport slave (
        input  pix_ce, hsync, vsync, r, g, b,
        output wr_en, wr_addr, wr_data
    );
endinterface

// File: rtl/vga_capture.sv
// Captures one active-low-sync RGB332 frame, decimated 4:1 per axis, into
// video RAM as 16-bit words holding two pixels, row pitch H_ACTIVE/8 words.
module vga_capture #(
    parameter int unsigned H_START  = 48,
    parameter int unsigned H_ACTIVE = 640,
    parameter int unsigned V_START  = 33,
    parameter int unsigned V_ACTIVE = 480
) (
    input  logic         clk,
    input  logic         rst_n,
    vga_capture_if.slave vid,
    input  logic         arm,
    output logic         busy,
    output logic         done,
    output logic         err
);
    localparam int unsigned PX_W   = 11;
    localparam int unsigned LN_W   = 10;
    localparam int unsigned ADDR_W = 15;
    localparam int unsigned PIX_W  = 8;

    localparam logic [PX_W-1:0]   PX_MAX    = PX_W'(2047);
    localparam logic [PX_W-1:0]   PX_PRE    = PX_W'(2046);
    localparam logic [PX_W-1:0]   H_LO      = PX_W'(H_START);
    localparam logic [PX_W-1:0]   H_HI      = PX_W'(H_START + H_ACTIVE);
    localparam logic [LN_W-1:0]   V_LO      = LN_W'(V_START);
    localparam logic [LN_W-1:0]   V_HI      = LN_W'(V_START + V_ACTIVE);
    localparam logic [2:0]        H_OFS     = 3'(H_START);
    localparam logic [1:0]        V_OFS     = 2'(V_START);
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'((V_ACTIVE / 4) * (H_ACTIVE / 8) - 1);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        WAIT_VS = 2'd1,
        CAPTURE = 2'd2
    } state_t;

    state_t             state;
    state_t             state_d;

    logic               pce_q;
    logic               hs_q;
    logic               hs_qq;
    logic               vs_q;
    logic               vs_qq;
    logic [PIX_W-1:0]   pix_q;

    logic [PX_W-1:0]    px;
    logic [LN_W-1:0]    ln;
    logic [ADDR_W-1:0]  word_cnt;
    logic [PIX_W-1:0]   hold;

    logic               hs_rise_c;
    logic               vs_rise_c;
    logic               h_act_c;
    logic               v_act_c;
    logic [2:0]         xi_lo_c;
    logic [1:0]         yi_lo_c;
    logic               sample_c;
    logic               px_sat_c;
    logic               last_word_c;

    logic               done_d;
    logic               err_d;
    logic               wr_en_d;
    logic               hold_ld_d;
    logic               cnt_clr_d;

    // Input stage; syncs reset to their inactive level so no edge appears at reset release.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pce_q <= 1'b0;
            hs_q  <= 1'b1;
            hs_qq <= 1'b1;
            vs_q  <= 1'b1;
            vs_qq <= 1'b1;
            pix_q <= '0;
        end else begin
            pce_q <= vid.pix_ce;
            hs_q  <= vid.hsync;
            hs_qq <= hs_q;
            vs_q  <= vid.vsync;
            vs_qq <= vs_q;
            pix_q <= {vid.b, vid.g, vid.r};
        end
    end

    assign hs_rise_c = hs_q & ~hs_qq;
    assign vs_rise_c = vs_q & ~vs_qq;

    // The strobe carrying the hsync edge is pixel 0 of the new line.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            px <= '0;
            ln <= '0;
        end else begin
            if (hs_rise_c) begin
                px <= pce_q ? PX_W'(1) : '0;
            end else if (pce_q && (px != PX_MAX)) begin
                px <= px + PX_W'(1);
            end

            if (vs_rise_c) begin
                ln <= hs_rise_c ? LN_W'(1) : '0;
            end else if (hs_rise_c) begin
                ln <= ln + LN_W'(1);
            end
        end
    end

    assign h_act_c     = (px >= H_LO) && (px < H_HI);
    assign v_act_c     = (ln >= V_LO) && (ln < V_HI);
    assign xi_lo_c     = px[2:0] - H_OFS;
    assign yi_lo_c     = ln[1:0] - V_OFS;
    assign sample_c    = pce_q && !hs_rise_c && h_act_c && v_act_c
                         && (xi_lo_c[1:0] == 2'd0) && (yi_lo_c == 2'd0);
    assign px_sat_c    = pce_q && !hs_rise_c && (px == PX_PRE);
    assign last_word_c = (word_cnt == LAST_ADDR);

    // State register and sticky status flags.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            busy  <= 1'b0;
            done  <= 1'b0;
            err   <= 1'b0;
        end else begin
            state <= state_d;
            busy  <= (state_d != IDLE);
            done  <= done_d;
            err   <= err_d;
        end
    end

    // Next state; a final write wins over a coincident vsync edge.
    always_comb begin
        state_d   = state;
        done_d    = done;
        err_d     = err;
        wr_en_d   = 1'b0;
        hold_ld_d = 1'b0;
        cnt_clr_d = 1'b0;
        case (state)
            IDLE: begin
                if (arm) begin
                    state_d = WAIT_VS;
                    done_d  = 1'b0;
                    err_d   = 1'b0;
                end
            end
            WAIT_VS: begin
                if (vs_rise_c) begin
                    state_d   = CAPTURE;
                    cnt_clr_d = 1'b1;
                end
            end
            CAPTURE: begin
                if (sample_c && xi_lo_c[2] && last_word_c) begin
                    wr_en_d = 1'b1;
                    state_d = IDLE;
                    done_d  = 1'b1;
                end else if (vs_rise_c || px_sat_c) begin
                    state_d = IDLE;
                    err_d   = 1'b1;
                end else begin
                    wr_en_d   = sample_c && xi_lo_c[2];
                    hold_ld_d = sample_c && !xi_lo_c[2];
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Write port, word address counter and even-pixel holding register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vid.wr_en   <= 1'b0;
            vid.wr_addr <= '0;
            vid.wr_data <= '0;
            word_cnt    <= '0;
            hold        <= '0;
        end else begin
            vid.wr_en <= wr_en_d;
            if (wr_en_d) begin
                vid.wr_addr <= word_cnt;
                vid.wr_data <= {pix_q, hold};
            end
            if (cnt_clr_d) begin
                word_cnt <= '0;
            end else if (wr_en_d) begin
                word_cnt <= word_cnt + ADDR_W'(1);
            end
            if (hold_ld_d) begin
                hold <= pix_q;
            end
        end
    end

endmodule
